// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: state encoding, counter sizing
// and the divide-by-zero quotient pattern.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Iteration counter width; a 1-bit floor keeps W=2 (and degenerate W) legal.
    function automatic int cw(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam logic [31:0] QUOT_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/addsub_w.sv
// N-bit combinational add/subtract with carry out; when sub=1 the borrow is ~cout.
module addsub_w #(
    parameter int N = 9
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] y,
    output logic         cout
);

    logic [N-1:0] b_eff;

    // Subtraction as a + ~b + 1, so carry out high means no borrow.
    assign b_eff     = sub ? ~b : b;
    assign {cout, y} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, sub};

endmodule

// File: rtl/vedic_div_seq.sv
// Iterative restoring unsigned divider, one quotient bit per clock, start/done handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// CALC  | W restoring iterations, one per cycle
// DONE  | one cycle, done pulses
module vedic_div_seq
    import div_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cw(W);

    state_t        state;
    logic [W:0]    r;
    logic [W-1:0]  q;
    logic [W-1:0]  dvs;
    logic [CW-1:0] count;

    logic [W:0]    r_sh;
    logic [W:0]    t;
    logic          no_borrow;
    logic [W:0]    r_nxt;
    logic [W-1:0]  q_nxt;
    logic          last_iter;
    logic          unused_r_msb;

    assign r_sh = {r[W-1:0], q[W-1]};

    addsub_w #(.N(W + 1)) u_trial_sub (
        .a    (r_sh),
        .b    ({1'b0, dvs}),
        .sub  (1'b1),
        .y    (t),
        .cout (no_borrow)
    );

    assign r_nxt     = no_borrow ? t : r_sh;
    assign q_nxt     = {q[W-2:0], no_borrow};
    assign last_iter = (count == CW'(W - 1));

    // The partial remainder's top bit only matters transiently inside r_sh.
    assign unused_r_msb = r[W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            dvs         <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= QUOT_ONES[W-1:0];
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            dvs   <= divisor;
                            r     <= '0;
                            q     <= dividend;
                            count <= '0;
                            busy  <= 1'b1;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r     <= r_nxt;
                    q     <= q_nxt;
                    count <= count + CW'(1);
                    if (last_iter) begin
                        quotient    <= q_nxt;
                        remainder   <= r_nxt[W-1:0];
                        div_by_zero <= 1'b0;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/vedic_div_seq.md
# vedic_div_seq

Parametrised, iterative unsigned divider: a W-bit dividend divided by a W-bit divisor, one quotient bit per clock, with a start/done handshake. It is the sequential core of the divider datapath. It builds on a parametrised add/subtract unit that generalises the fixed 2-bit adder to W+1 bits with borrow out, and it feeds the top-level result registers.

## Interface
Parameters:
- W, default 8: operand, quotient and remainder width; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a division; sampled on clk.
- dividend  input  W  unsigned dividend; sampled when start is accepted.
- divisor  input  W  unsigned divisor; sampled when start is accepted.
- busy  output  1  high while an iteration is in progress.
- done  output  1  single-cycle pulse; results are valid from this cycle onwards.
- quotient  output  W  unsigned quotient.
- remainder  output  W  unsigned remainder.
- div_by_zero  output  1  set with done when divisor was 0; held with the results.

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: W iterations, one per cycle.
  - DONE: one cycle, pulses done.
- IDLE, start=1, divisor≠0: latch the operands, clear the partial remainder R (W+1 bits), set the quotient shift register to the dividend, set count=0, move to CALC.
- IDLE, start=1, divisor=0: move directly to DONE with these results:
  - quotient = all ones.
  - remainder = dividend.
  - div_by_zero = 1.
- Each CALC cycle is one restoring step:
  - R' = {R[W-1:0], Q[W-1]}.
  - T = R' − {1'b0, divisor}, computed in W+1 bits by the add/sub unit.
  - No borrow: R = T and a quotient bit of 1 is shifted into Q[0].
  - Borrow: R = R' and a quotient bit of 0 is shifted into Q[0].
  - count increments.
- When count reaches W−1 and that iteration completes: register quotient = Q and remainder = R[W-1:0], clear div_by_zero, move to DONE.
- DONE always returns to IDLE on the next edge. done=1 only in DONE.
- start is ignored in CALC and DONE. Operand changes after acceptance have no effect.
- quotient, remainder and div_by_zero hold their last values until the next accepted start produces new results. They do not change during CALC.
- Invariant: dividend = quotient·divisor + remainder and remainder < divisor, for every divisor ≠ 0.

## Timing
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - busy, done, quotient, remainder and div_by_zero go to 0.
  - Internal R, Q and count go to 0.
  - Any division in flight is discarded, and no done is produced for it.
- Start accepted at edge k with a nonzero divisor:
  - busy is high for cycles k..k+W−1, i.e. W cycles.
  - done is high for the single cycle after edge k+W.
  - Results are valid in that cycle.
- Divide by zero accepted at edge k: done and div_by_zero are high in the cycle after edge k; busy never asserts.
- Back-to-back operation: start held high continuously is accepted again at the edge that leaves DONE? No: DONE goes to IDLE, and the next acceptance happens in IDLE.
  - Minimum spacing between accepted starts is W+2 edges.
  - Minimum spacing for divide by zero is 2 edges.
- rst deasserting while start=1: start is accepted at the first rising clk edge with rst low.

## Structure
- Shared package / header div_pkg holds:
  - The state encoding constants: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - The counter width function: CW = $clog2(W).
  - The all-ones quotient constant used for divide by zero.
- One sub-module, addsub_w:
  - Parameter N (set to W+1).
  - Inputs a[N], b[N], sub.
  - Outputs y[N] and cout; borrow = ~cout when sub=1.
  - Purely combinational.
  - Instantiated once for the trial subtraction.
- The FSM, counter and shift registers live in vedic_div_seq.

## Test plan
- W=8, start with 100/7 -> busy for 8 cycles; done pulses exactly 8 cycles after the start edge; quotient=14, remainder=2, div_by_zero=0.
- W=8, 255/1, then 5/9, then 0/3 -> (255,0), (5 gives q=0, r=5), (0,0). Each case gets exactly one done pulse, and the outputs hold between runs.
- W=8, 77/0 -> done the next cycle; quotient=0xFF, remainder=77, div_by_zero=1; busy stays 0. A following 77/7 then gives 11/0 with div_by_zero cleared.
- W=8, start held high for 30 cycles with 200/3 -> exactly one division per 10-edge window (W+2); every result is 66/2. Operands changed mid-CALC do not alter the result.
- W=8, rst asserted at iteration 4 of 200/13 -> all outputs 0 immediately, with no clock edge needed. No done pulse follows. A new 200/13 after release gives 15/5.
- W=16 and W=4, random operands over 1000 runs -> the invariant holds against the reference model; latency is exactly W.
